// File: rtl/det_result_pkg.sv
// rtl/det_result_pkg.sv - output word field positions and packing helpers for det_result_collector
package det_result_pkg;

    localparam int DET_FLAG_BIT = 31;
    localparam int FRAME_LSB    = 23;
    localparam int FRAME_W      = 8;
    localparam int CNT_W        = 16;

    typedef struct packed {
        logic               flag;
        logic [FRAME_W-1:0] frame;
        logic [FRAME_LSB-1:0] id;
    } det_word_t;

    typedef struct packed {
        logic                       flag;
        logic [FRAME_W-1:0]         frame;
        logic [FRAME_LSB-CNT_W-1:0] rsvd;
        logic [CNT_W-1:0]           cnt;
    } sum_word_t;

    function automatic det_word_t pack_det(input logic [FRAME_W-1:0] frame,
                                           input logic [FRAME_LSB-1:0] id);
        det_word_t w;
        w.flag  = 1'b0;
        w.frame = frame;
        w.id    = id;
        return w;
    endfunction

    function automatic sum_word_t pack_sum(input logic [FRAME_W-1:0] frame,
                                           input logic [CNT_W-1:0] cnt);
        sum_word_t w;
        w.flag  = 1'b1;
        w.frame = frame;
        w.rsvd  = '0;
        w.cnt   = cnt;
        return w;
    endfunction

endpackage

// File: rtl/det_fifo.sv
// rtl/det_fifo.sv - synchronous detection FIFO; pushes to a full FIFO are dropped
module det_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    // A pop in the same cycle never makes room for a push into a full FIFO.
    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/det_result_collector.sv
// rtl/det_result_collector.sv - queues person detections plus a per-frame summary onto a 32-bit stream
// Optional person LED stretcher enabled by DET_LED_EN.
module det_result_collector
    import det_result_pkg::*;
#(
    parameter int SW_W       = 11,
    parameter int SW_NUM     = 495,
    parameter int FIFO_DEPTH = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            res_valid_i,
    input  logic            res_person_i,
    input  logic [SW_W-1:0] res_sw_id_i,
    output logic [31:0]     m_tdata_o,
    output logic            m_tvalid_o,
    output logic            m_tlast_o,
    input  logic            m_tready_i,
    input  logic            clr_i,
    output logic [7:0]      frame_cnt_o,
    output logic            ovf_o,
    output logic            seq_err_o,
    output logic            led_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [SW_W-1:0]    win_idx;
    logic [FRAME_W-1:0] frame_cnt;
    logic [CNT_W-1:0]   det_cnt;
    logic [CNT_W-1:0]   det_cnt_nxt;
    logic               sum_pending;
    sum_word_t          sum_word;
    logic [CW-1:0]      sum_left;

    logic               det;
    logic               frame_end;
    logic               fifo_sel;
    logic               pop_done;
    logic               sum_xfer;
    logic               sum_drop;
    logic               det_drop;
    logic               seq_bad;

    logic [31:0]        fifo_rdata;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [CW-1:0]      occ_nxt;

    assign det         = res_valid_i & res_person_i;
    assign frame_end   = res_valid_i && (win_idx == SW_W'(SW_NUM - 1));
    assign det_cnt_nxt = (det && det_cnt != '1) ? det_cnt + 1'b1 : det_cnt;
    assign seq_bad     = res_valid_i && (res_sw_id_i != win_idx);

    // Words queued before the summary drain first; later-frame words wait behind it.
    assign fifo_sel   = ~sum_pending | (sum_left != '0);
    assign m_tvalid_o = fifo_sel ? ~fifo_empty : 1'b1;
    assign m_tdata_o  = fifo_sel ? (fifo_empty ? 32'd0 : fifo_rdata) : sum_word;
    assign m_tlast_o  = ~fifo_sel & sum_word[DET_FLAG_BIT];

    assign pop_done = fifo_sel & m_tready_i & ~fifo_empty;
    assign sum_xfer = ~fifo_sel & m_tready_i;
    assign sum_drop = frame_end & sum_pending & ~sum_xfer;
    assign det_drop = det & fifo_full;
    assign occ_nxt  = fifo_count + CW'(det & ~fifo_full) - CW'(pop_done);

    det_fifo #(
        .W     (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (det),
        .wdata (pack_det(frame_cnt, FRAME_LSB'(res_sw_id_i))),
        .pop   (fifo_sel & m_tready_i),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_idx     <= '0;
            frame_cnt   <= '0;
            det_cnt     <= '0;
            sum_pending <= 1'b0;
            sum_word    <= '0;
            sum_left    <= '0;
            ovf_o       <= 1'b0;
            seq_err_o   <= 1'b0;
        end else begin
            if (res_valid_i) begin
                win_idx <= frame_end ? '0 : win_idx + 1'b1;
            end
            if (frame_end) begin
                frame_cnt <= frame_cnt + 1'b1;
                det_cnt   <= '0;
            end else begin
                det_cnt <= det_cnt_nxt;
            end

            if (frame_end && !sum_drop) begin
                sum_pending <= 1'b1;
                sum_word    <= pack_sum(frame_cnt, det_cnt_nxt);
                sum_left    <= occ_nxt;
            end else begin
                if (sum_xfer) begin
                    sum_pending <= 1'b0;
                end
                if (sum_pending && pop_done) begin
                    sum_left <= sum_left - 1'b1;
                end
            end

            ovf_o     <= (ovf_o & ~clr_i) | det_drop | sum_drop;
            seq_err_o <= (seq_err_o & ~clr_i) | seq_bad;
        end
    end

    assign frame_cnt_o = frame_cnt;

`ifdef DET_LED_EN
    localparam int LED_HOLD  = 2 ** 20;
    localparam int LED_CNT_W = $clog2(LED_HOLD + 1);

    logic [LED_CNT_W-1:0] led_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_cnt <= '0;
        end else if (det) begin
            led_cnt <= LED_CNT_W'(LED_HOLD);
        end else if (led_cnt != '0) begin
            led_cnt <= led_cnt - 1'b1;
        end
    end

    assign led_o = (led_cnt != '0);
`else
    assign led_o = 1'b0;
`endif

endmodule

// File: tb/tb_det_result_collector.sv
// tb/tb_det_result_collector.sv - randomized self-checking bench for det_result_collector
module tb_det_result_collector;

    localparam int SW_NUM     = 495;
    localparam int FIFO_DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        res_valid_i = 1'b0;
    logic        res_person_i = 1'b0;
    logic [10:0] res_sw_id_i = '0;
    logic [31:0] m_tdata_o;
    logic        m_tvalid_o;
    logic        m_tlast_o;
    logic        m_tready_i = 1'b0;
    logic        clr_i = 1'b0;
    logic [7:0]  frame_cnt_o;
    logic        ovf_o;
    logic        seq_err_o;
    logic        led_o;

    det_result_collector dut (
        .clk          (clk),
        .rst          (rst),
        .res_valid_i  (res_valid_i),
        .res_person_i (res_person_i),
        .res_sw_id_i  (res_sw_id_i),
        .m_tdata_o    (m_tdata_o),
        .m_tvalid_o   (m_tvalid_o),
        .m_tlast_o    (m_tlast_o),
        .m_tready_i   (m_tready_i),
        .clr_i        (clr_i),
        .frame_cnt_o  (frame_cnt_o),
        .ovf_o        (ovf_o),
        .seq_err_o    (seq_err_o),
        .led_o        (led_o)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          pmask [SW_NUM];
    logic [32:0] got [$];
    logic [32:0] exp [$];
    int          m_win;
    int          m_det;
    int          m_occ;
    logic [7:0]  m_frame;

    always @(negedge clk) begin
        if (!rst && m_tvalid_o && m_tready_i) begin
            got.push_back({m_tlast_o, m_tdata_o});
        end
    end

    function automatic logic pick_ready(input int rmode);
        if (rmode == 0) return 1'b1;
        if (rmode == 1) return 1'b0;
        return ($urandom_range(3) != 0);
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        res_valid_i = 1'b0;
        res_person_i = 1'b0;
        clr_i = 1'b0;
        m_tready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        got.delete();
        exp.delete();
        m_win = 0;
        m_det = 0;
        m_occ = 0;
        m_frame = 8'd0;
    endtask

    // Drives one window result and advances the frame-level model.
    task automatic drive_result(input logic [10:0] id, input bit person, input int rmode, input bit stalled);
        res_valid_i = 1'b1;
        res_person_i = person;
        res_sw_id_i = id;
        m_tready_i = pick_ready(rmode);
        if (person) begin
            if (!(stalled && m_occ >= FIFO_DEPTH)) begin
                exp.push_back({1'b0, (32'(m_frame) << 23) | 32'(id)});
                m_occ++;
            end
            if (m_det < 65535) m_det++;
        end
        if (m_win == SW_NUM - 1) begin
            exp.push_back({1'b1, 32'h8000_0000 | (32'(m_frame) << 23) | 32'(m_det)});
            m_frame = m_frame + 8'd1;
            m_det = 0;
            m_win = 0;
        end else begin
            m_win++;
        end
        @(posedge clk);
        #1;
        res_valid_i = 1'b0;
        res_person_i = 1'b0;
    endtask

    task automatic feed_frame(input int rmode, input bit stalled, input int bad_idx);
        for (int w = 0; w < SW_NUM; w++) begin
            drive_result((w == bad_idx) ? 11'(w + 1) : 11'(w), pmask[w], rmode, stalled);
        end
    endtask

    task automatic drain(input int rmode);
        int guard = 0;
        while (got.size() < exp.size() && guard < 4000) begin
            m_tready_i = pick_ready(rmode);
            @(posedge clk);
            #1;
            guard++;
        end
        m_tready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++;
        if ({m_tvalid_o, m_tlast_o, m_tdata_o} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_stream: valid/last/data=%b/%b/%h required 0/0/0", m_tvalid_o, m_tlast_o, m_tdata_o);
        end
        n_tests++;
        if ({frame_cnt_o, ovf_o, seq_err_o, led_o} !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_status: frame=%0d ovf=%b seq=%b led=%b required all 0", frame_cnt_o, ovf_o, seq_err_o, led_o);
        end
    endtask

    task automatic test_one_frame();
        do_reset();
        for (int w = 0; w < SW_NUM; w++) pmask[w] = (w == 5 || w == 100 || w == 494);
        for (int w = 0; w < SW_NUM; w++) begin
            drive_result(11'(w), pmask[w], 0, 1'b0);
            if (w == 5) begin
                n_tests++;
                if (m_tvalid_o !== 1'b1 || m_tdata_o !== 32'h0000_0005) begin
                    n_fail++;
                    $display("FAIL latency: valid=%b data=%h required 1 00000005", m_tvalid_o, m_tdata_o);
                end
`ifdef DET_LED_EN
                n_tests++;
                if (led_o !== 1'b1) begin
                    n_fail++;
                    $display("FAIL led_on: led=%b required 1", led_o);
                end
`endif
            end
        end
        drain(0);
        n_tests++;
        if (got.size() != exp.size()) begin
            n_fail++;
            $display("FAIL one_frame_count: got %0d words required %0d", got.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            n_tests++;
            if (got[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL one_frame_word%0d: got %h required %h", i, got[i], exp[i]);
            end
        end
        n_tests++;
        if (got.size() != 4 || got[3] !== 33'h1_8000_0003) begin
            n_fail++;
            $display("FAIL one_frame_summary: size %0d last %h required 4 words ending 1_80000003", got.size(), got[got.size()-1]);
        end
        n_tests++;
        if (frame_cnt_o !== 8'd1) begin
            n_fail++;
            $display("FAIL one_frame_cnt: frame_cnt=%0d required 1", frame_cnt_o);
        end
    endtask

    task automatic test_empty_frame();
        do_reset();
        for (int w = 0; w < SW_NUM; w++) pmask[w] = 1'b0;
        feed_frame(0, 1'b0, -1);
        feed_frame(0, 1'b0, -1);
        drain(0);
        n_tests++;
        if (got.size() != 2 || got[0] !== 33'h1_8000_0000 || got[1] !== 33'h1_8080_0000) begin
            n_fail++;
            $display("FAIL empty_frames: size %0d first %h required 2 words 1_80000000, 1_80800000", got.size(), got[0]);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] first;
        int          bad = 0;
        do_reset();
        for (int w = 0; w < SW_NUM; w++) begin
            drive_result(11'(w), (w >= 10 && w < 80), 1, 1'b1);
            if (w == 10) first = m_tdata_o;
            if (w > 10 && (m_tvalid_o !== 1'b1 || m_tdata_o !== first || m_tlast_o !== 1'b0)) bad++;
        end
        n_tests++;
        if (bad != 0 || first !== 32'h0000_000A) begin
            n_fail++;
            $display("FAIL stall_stable: %0d unstable cycles, head %h required 0 and 0000000a", bad, first);
        end
        n_tests++;
        if (ovf_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: ovf=%b required 1", ovf_o);
        end
        drain(0);
        n_tests++;
        if (got.size() != exp.size()) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d words required %0d", got.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            n_tests++;
            if (got[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL ovf_word%0d: got %h required %h", i, got[i], exp[i]);
            end
        end
        n_tests++;
        if (got.size() != 65 || got[64] !== 33'h1_8000_0046) begin
            n_fail++;
            $display("FAIL ovf_summary: size %0d required 65 words ending 1_80000046", got.size());
        end
    endtask

    task automatic test_seq_err();
        do_reset();
        m_tready_i = 1'b1;
        for (int w = 0; w < SW_NUM - 1; w++) begin
            drive_result((w == 6) ? 11'd7 : 11'(w), 1'b0, 0, 1'b0);
        end
        n_tests++;
        if (seq_err_o !== 1'b1 || frame_cnt_o !== 8'd0) begin
            n_fail++;
            $display("FAIL seq_err_set: seq=%b frame=%0d required 1 0", seq_err_o, frame_cnt_o);
        end
        drive_result(11'd494, 1'b0, 0, 1'b0);
        n_tests++;
        if (frame_cnt_o !== 8'd1) begin
            n_fail++;
            $display("FAIL seq_frame_end: frame=%0d required 1", frame_cnt_o);
        end
        clr_i = 1'b1;
        @(posedge clk);
        #1 clr_i = 1'b0;
        n_tests++;
        if (seq_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_clr: seq=%b required 0", seq_err_o);
        end
        clr_i = 1'b1;
        drive_result(11'd5, 1'b0, 0, 1'b0);
        clr_i = 1'b0;
        n_tests++;
        if (seq_err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL seq_clr_same_cycle: seq=%b required 1", seq_err_o);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int w = 0; w < SW_NUM; w++) pmask[w] = (w == 494);
        feed_frame(2, 1'b0, -1);
        drive_result(11'd0, 1'b1, 2, 1'b0);
        drain(2);
        n_tests++;
        if (got.size() != exp.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d words required %0d", got.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            n_tests++;
            if (got[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL b2b_word%0d: got %h required %h", i, got[i], exp[i]);
            end
        end
        n_tests++;
        if (got.size() != 3 || got[1] !== 33'h1_8000_0001 || got[2] !== 33'h0_0080_0000) begin
            n_fail++;
            $display("FAIL b2b_order: size %0d mid %h required 3 words, summary 1_80000001 then 0_00800000", got.size(), got[1]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int f = 0; f < 3; f++) begin
            for (int w = 0; w < SW_NUM; w++) pmask[w] = ($urandom_range(9) == 0);
            feed_frame(2, 1'b0, -1);
        end
        drain(2);
        n_tests++;
        if (got.size() != exp.size()) begin
            n_fail++;
            $display("FAIL random_count: got %0d words required %0d", got.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            n_tests++;
            if (got[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL random_word%0d: got %h required %h", i, got[i], exp[i]);
            end
        end
        n_tests++;
        if (ovf_o !== 1'b0 || seq_err_o !== 1'b0 || frame_cnt_o !== m_frame) begin
            n_fail++;
            $display("FAIL random_status: ovf=%b seq=%b frame=%0d required 0 0 %0d", ovf_o, seq_err_o, frame_cnt_o, m_frame);
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        for (int w = 0; w < 10; w++) drive_result(11'(w), 1'b1, 1, 1'b1);
        n_tests++;
        if (m_tvalid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_pre: valid=%b required 1", m_tvalid_o);
        end
        rst = 1'b1;
        #1;
`ifdef DET_LED_EN
        n_tests++;
        if (led_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_led: led=%b required 0", led_o);
        end
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        n_tests++;
        if (m_tvalid_o !== 1'b0 || frame_cnt_o !== 8'd0 || m_tdata_o !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_mid_post: valid=%b frame=%0d data=%h required 0 0 0", m_tvalid_o, frame_cnt_o, m_tdata_o);
        end
        got.delete();
        exp.delete();
    endtask

    initial begin
        test_reset();
        test_one_frame();
        test_empty_frame();
        test_overflow();
        test_seq_err();
        test_back_to_back();
        test_random();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
